// File: rtl/hdc_msg_sequencer.sv
// hdc_msg_sequencer
// Sequences the HDC spam/ham datapath for one message at a time. A packed
// message is accepted, the encoder accumulator is cleared, the characters
// are streamed one per accepted beat, and the classifier is then triggered.
// The 2-bit verdict is reported, or 2'b11 (inconclusive) on an empty message
// or a classifier timeout.
//
// Handshake rule for msg_valid/msg_ready and enc_char_valid/enc_char_ready:
// a transfer happens on a rising edge where both valid and ready are high.
// While valid is high and ready is low, the payload is held stable.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   msg_valid/ready   message input handshake (ready only in IDLE)
//   msg, length       packed message (char 0 leftmost) and char count
//   enc_clear         one-cycle pulse to clear the encoder accumulator
//   enc_char_*        character stream to the encoder
//   cls_start         one-cycle pulse that starts classification
//   cls_done/label    classifier completion and verdict
//   result_valid      one-cycle pulse when result is updated
//   result            last verdict, 2'b11 = inconclusive
//   busy              high outside IDLE
//   state_dbg         current FSM state for debug/checkers
module hdc_msg_sequencer #(
  parameter int MESSAGE_LENGTH = 200,
  parameter int CHAR_LENGTH    = 8,
  parameter int LEN_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  msg_valid,
  output logic                                  msg_ready,
  input  logic [CHAR_LENGTH*MESSAGE_LENGTH-1:0] msg,
  input  logic [LEN_WIDTH-1:0]                  length,
  output logic                                  enc_clear,
  output logic                                  enc_char_valid,
  input  logic                                  enc_char_ready,
  output logic [CHAR_LENGTH-1:0]                enc_char,
  output logic                                  enc_char_last,
  output logic                                  cls_start,
  input  logic                                  cls_done,
  input  logic [1:0]                            cls_label,
  output logic                                  result_valid,
  output logic [1:0]                            result,
  output logic                                  busy,
  output logic [2:0]                            state_dbg
);

  localparam int MSG_W = CHAR_LENGTH * MESSAGE_LENGTH;
  localparam int IDX_W = (MESSAGE_LENGTH > 1) ? $clog2(MESSAGE_LENGTH) : 1;
  localparam int LEN_W = $clog2(MESSAGE_LENGTH + 1);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_STREAM   = 3'd2,
    S_CLASSIFY = 3'd3,
    S_WAIT     = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic [LEN_W-1:0]   eff_len_q, eff_len_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         result_q, result_d;

  logic [31:0]        len_ext;
  logic [LEN_W-1:0]   eff_len_in;
  logic               is_last;

  // Clamp in 32 bits so a length field narrower or wider than the message
  // capacity compares correctly without wrap.
  assign len_ext    = 32'(length);
  assign eff_len_in = (len_ext > 32'(MESSAGE_LENGTH)) ? LEN_W'(MESSAGE_LENGTH)
                                                      : LEN_W'(len_ext);

  // eff_len is at least 1 whenever STREAM is reached, so idx+1 == eff_len
  // is the unsigned form of idx == eff_len-1.
  assign is_last = ((32'(idx_q) + 32'd1) == 32'(eff_len_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      msg_q     <= '0;
      eff_len_q <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      result_q  <= 2'b11;
    end else begin
      state_q   <= state_d;
      msg_q     <= msg_d;
      eff_len_q <= eff_len_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    msg_d     = msg_q;
    eff_len_d = eff_len_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (msg_valid) begin
          msg_d     = msg;
          eff_len_d = eff_len_in;
          if (eff_len_in == '0) begin
            result_d = 2'b11;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        idx_d   = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (enc_char_ready) begin
          // The message is kept as a shift register: the current char is
          // always the top slice, so an accept just shifts the next one up.
          msg_d = msg_q << CHAR_LENGTH;
          if (is_last) begin
            state_d = S_CLASSIFY;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_CLASSIFY: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // cls_done is tested first so it wins over a coincident timeout.
        if (cls_done) begin
          result_d = cls_label;
          state_d  = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          result_d = 2'b11;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign msg_ready      = (state_q == S_IDLE);
  assign enc_clear      = (state_q == S_CLEAR);
  assign enc_char_valid = (state_q == S_STREAM);
  assign enc_char       = enc_char_valid ? msg_q[MSG_W-1 -: CHAR_LENGTH] : '0;
  assign enc_char_last  = enc_char_valid && is_last;
  assign cls_start      = (state_q == S_CLASSIFY);
  assign result_valid   = (state_q == S_DONE);
  assign result         = result_q;
  assign busy           = (state_q != S_IDLE);
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_hdc_msg_sequencer.sv
// Testbench for hdc_msg_sequencer: directed messages, an automatic
// classifier responder and a transaction-level reference model.
module tb_hdc_msg_sequencer;

  localparam int ML = 200;
  localparam int CL = 8;
  localparam int LW = 8;
  localparam int TO = 16;
  localparam int MW = ML * CL;

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          reset;
  logic          msg_valid;
  logic          msg_ready;
  logic [MW-1:0] msg;
  logic [LW-1:0] length;
  logic          enc_clear;
  logic          enc_char_valid;
  logic          enc_char_ready;
  logic [CL-1:0] enc_char;
  logic          enc_char_last;
  logic          cls_start;
  logic          cls_done;
  logic [1:0]    cls_label;
  logic          result_valid;
  logic [1:0]    result;
  logic          busy;
  logic [2:0]    state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hdc_msg_sequencer #(
    .MESSAGE_LENGTH(ML), .CHAR_LENGTH(CL), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg(msg), .length(length), .enc_clear(enc_clear),
    .enc_char_valid(enc_char_valid), .enc_char_ready(enc_char_ready),
    .enc_char(enc_char), .enc_char_last(enc_char_last), .cls_start(cls_start),
    .cls_done(cls_done), .cls_label(cls_label), .result_valid(result_valid),
    .result(result), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- counters / knobs ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  int         done_delay = 2;     // cycles from cls_start to cls_done; <=0 = never
  logic [1:0] done_label = 2'b01;
  int         ready_mode = 0;     // 0: always ready, 1: ready on even cycles

  // ---------------- reference model state ----------------
  logic [CL-1:0] exp_q[$];
  int         exp_clear_cyc = -100;
  int         exp_start_cyc = -100;
  int         exp_res_cyc   = -100;
  int         done_at       = -100;
  logic [1:0] exp_res_val   = 2'b11;
  logic [1:0] model_result  = 2'b11;
  bit         active        = 1'b0;
  bit         streaming     = 1'b0;
  int         last_hs_cyc   = -100;
  int         accept_cnt    = 0;
  int         last_flag_idx = -1;
  int         start_seen_cyc = -100;
  int         res_seen_cyc  = -100;
  logic [1:0] res_seen_val  = 2'b00;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_clear_cyc = -100;
    exp_start_cyc = -100;
    exp_res_cyc   = -100;
    done_at       = -100;
    active        = 1'b0;
    streaming     = 1'b0;
    model_result  = 2'b11;
  endtask

  // ---------------- compare process (every negedge) ----------------
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc > 2) begin
        if (reset) begin
          model_reset();
        end else begin
          if (cyc == exp_res_cyc) model_result = exp_res_val;
          chk("busy", int'(busy), int'(active));
          chk("msg_ready", int'(msg_ready), int'(!active));
          chk("enc_clear", int'(enc_clear), int'(cyc == exp_clear_cyc));
          chk("enc_char_valid", int'(enc_char_valid), int'(streaming));
          if (streaming && exp_q.size() > 0) begin
            chk("enc_char", int'(enc_char), int'(exp_q[0]));
            chk("enc_char_last", int'(enc_char_last), int'(exp_q.size() == 1));
          end else begin
            chk("enc_char_last_idle", int'(enc_char_last), 0);
          end
          chk("cls_start", int'(cls_start), int'(cyc == exp_start_cyc));
          chk("result_valid", int'(result_valid), int'(cyc == exp_res_cyc));
          chk("result", int'(result), int'(model_result));
          if (cls_start) start_seen_cyc = cyc;
          if (result_valid) begin
            res_seen_cyc = cyc;
            res_seen_val = result;
          end

          if (!active) begin
            if (msg_valid) begin
              int eff;
              eff = (int'(length) > ML) ? ML : int'(length);
              last_hs_cyc   = cyc;
              accept_cnt    = 0;
              last_flag_idx = -1;
              exp_q.delete();
              for (int i = 0; i < eff; i++) exp_q.push_back(msg[MW-1-i*CL -: CL]);
              if (eff == 0) begin
                exp_res_cyc = cyc + 1;
                exp_res_val = 2'b11;
              end else begin
                exp_clear_cyc = cyc + 1;
              end
              active = 1'b1;
            end
          end else begin
            if (streaming && enc_char_ready) begin
              if (enc_char_last) last_flag_idx = accept_cnt;
              void'(exp_q.pop_front());
              accept_cnt++;
              if (exp_q.size() == 0) begin
                streaming     = 1'b0;
                exp_start_cyc = cyc + 1;
              end
            end
            if (cyc == exp_clear_cyc) streaming = 1'b1;
            if (cyc == exp_start_cyc) begin
              if (done_delay > 0) begin
                done_at     = cyc + done_delay;
                exp_res_cyc = done_at + 1;
                exp_res_val = done_label;
              end else begin
                exp_res_cyc = cyc + 1 + TO;
                exp_res_val = 2'b11;
              end
            end
            if (cyc == exp_res_cyc) active = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- driver: encoder ready and classifier responder ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      enc_char_ready = (ready_mode == 0) ? 1'b1 : (((cyc + 1) % 2) == 0);
      cls_done       = ((cyc + 1) == done_at);
      cls_label      = cls_done ? done_label : 2'($urandom_range(0, 3));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic submit(input logic [MW-1:0] m, input int len);
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    msg_valid = 1'b1;
    msg       = m;
    length    = LW'(len);
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      #1;
      if (last_hs_cyc == cyc) got = 1'b1;
    end
    chk("handshake_seen", int'(got), 1);
    @(posedge clk);
    #1;
    msg_valid = 1'b0;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((active || exp_res_cyc >= cyc) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("idle_reached", int'(n < budget), 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_msg_ready"}, int'(msg_ready), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_enc_clear"}, int'(enc_clear), 0);
    chk({tag, "_enc_char_valid"}, int'(enc_char_valid), 0);
    chk({tag, "_enc_char_last"}, int'(enc_char_last), 0);
    chk({tag, "_enc_char"}, int'(enc_char), 0);
    chk({tag, "_cls_start"}, int'(cls_start), 0);
    chk({tag, "_result_valid"}, int'(result_valid), 0);
    chk({tag, "_result"}, int'(result), 3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    logic [MW-1:0] m;
    int h;
    reset = 1'b1; msg_valid = 1'b0; msg = '0; length = '0;
    enc_char_ready = 1'b1; cls_done = 1'b0; cls_label = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    #1;
    check_reset_vals("reset");

    // Basic "abc", label 01, cls_done two cycles after cls_start
    ready_mode = 0; done_delay = 2; done_label = 2'b01;
    m = '0;
    m[MW-1 -: 24] = 24'h616263;
    submit(m, 3);
    h = last_hs_cyc;
    wait_to(h + 1); chk("basic_clear_c1", int'(enc_clear), 1);
    wait_to(h + 2); chk("basic_char_c2", int'(enc_char), 'h61);
    chk("basic_last_c2", int'(enc_char_last), 0);
    wait_to(h + 3); chk("basic_char_c3", int'(enc_char), 'h62);
    wait_to(h + 4); chk("basic_char_c4", int'(enc_char), 'h63);
    chk("basic_last_c4", int'(enc_char_last), 1);
    wait_to(h + 5); chk("basic_start_c5", int'(cls_start), 1);
    wait_to(h + 8); chk("basic_rv_c8", int'(result_valid), 1);
    chk("basic_result_c8", int'(result), 1);
    wait_idle(50);

    // Backpressure: ready on even cycles, stray msg_valid while busy
    ready_mode = 1; done_delay = 3; done_label = 2'b00;
    m = '0;
    m[MW-1 -: 32] = 32'h7778797a;
    submit(m, 4);
    @(posedge clk); #1;
    msg_valid = 1'b1; msg = '1; length = LW'(5);
    repeat (3) @(posedge clk);
    #1;
    msg_valid = 1'b0;
    wait_idle(100);
    chk("bp_accepts", accept_cnt, 4);
    chk("bp_result", int'(res_seen_val), 0);

    // Empty message
    ready_mode = 0;
    m = '0;
    m[MW-1 -: 16] = 16'h4142;
    submit(m, 0);
    h = last_hs_cyc;
    wait_to(h + 1);
    chk("empty_rv_c1", int'(result_valid), 1);
    chk("empty_result_c1", int'(result), 3);
    chk("empty_no_clear", int'(enc_clear), 0);
    wait_idle(20);
    chk("empty_accepts", accept_cnt, 0);

    // Length clamp: 250 requested, 200 streamed
    done_delay = 1; done_label = 2'b01;
    m = '0;
    for (int i = 0; i < ML; i++) m[MW-1-i*CL -: CL] = CL'(i) ^ 8'h5a;
    submit(m, 250);
    wait_idle(400);
    chk("clamp_accepts", accept_cnt, 200);
    chk("clamp_last_idx", last_flag_idx, 199);
    chk("clamp_result", int'(res_seen_val), 1);

    // Timeout: classifier never answers
    done_delay = -1;
    m = '0;
    m[MW-1 -: 16] = 16'h6869;
    submit(m, 2);
    wait_idle(100);
    chk("to_latency", res_seen_cyc - start_seen_cyc, TO + 1);
    chk("to_result", int'(res_seen_val), 3);
    @(negedge clk); #1;
    chk("to_busy_after", int'(busy), 0);
    chk("to_ready_after", int'(msg_ready), 1);

    // Reset while streaming at idx 5, then a fresh 2-char message
    done_delay = 2; done_label = 2'b01;
    m = '0;
    for (int i = 0; i < 10; i++) m[MW-1-i*CL -: CL] = 8'h30 + CL'(i);
    submit(m, 10);
    h = last_hs_cyc;
    wait_to(h + 6);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;
    chk("rst_idx5_char", int'(enc_char), 'h35);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    check_reset_vals("midrst");
    done_label = 2'b10;
    m = '0;
    m[MW-1 -: 16] = 16'h6869;
    submit(m, 2);
    wait_idle(50);
    chk("rst_new_accepts", accept_cnt, 2);
    chk("rst_new_result", int'(res_seen_val), 2);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hdc_msg_sequencer.md
Name: hdc_msg_sequencer

Overview:
Controller that sequences the HDC spam/ham classification datapath for one message at a time. It accepts a packed message plus its length through a valid/ready handshake. It then clears the encoder's accumulator and streams the message characters one at a time into the encoder. Finally it triggers the similarity/classification stage and returns a 2-bit label, with inconclusive (2'b11) reported on empty input or classifier timeout.

Parameters:
MESSAGE_LENGTH, 200, max characters per message
CHAR_LENGTH, 8, bits per character
LEN_WIDTH, 8, width of the length field
TIMEOUT_CYCLES, 1024, max cycles to wait for cls_done (must be >= 2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
msg_valid  input  1  message and length are valid
msg_ready  output  1  sequencer can accept a message
msg  input  CHAR_LENGTH*MESSAGE_LENGTH  packed message; char 0 = msg[CHAR_LENGTH*MESSAGE_LENGTH-1 -: CHAR_LENGTH] (leftmost)
length  input  LEN_WIDTH  number of valid chars
enc_clear  output  1  one-cycle pulse: clear encoder accumulator
enc_char_valid  output  1  enc_char is valid
enc_char_ready  input  1  encoder accepts the char
enc_char  output  CHAR_LENGTH  current character
enc_char_last  output  1  current char is the final one
cls_start  output  1  one-cycle pulse: start classification
cls_done  input  1  classifier finished, cls_label valid
cls_label  input  2  classifier verdict (00 ham, 01 spam)
result_valid  output  1  one-cycle pulse: result updated
result  output  2  last verdict; 2'b11 = inconclusive
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - State = IDLE, msg_ready = 1.
  - enc_clear, enc_char_valid, enc_char_last, cls_start, result_valid, busy = 0.
  - enc_char = 0, result = 2'b11.
- Reset mid-operation returns to IDLE on the next edge. The captured message is discarded and no result_valid is produced.
- FSM states: IDLE, CLEAR, STREAM, CLASSIFY, WAIT, DONE.
- IDLE:
  - msg_ready = 1.
  - On msg_valid: register msg and eff_len = min(length, MESSAGE_LENGTH).
  - If eff_len == 0: go to DONE with result <= 2'b11. Otherwise go to CLEAR.
- CLEAR: enc_clear = 1 for exactly one cycle; idx <= 0; go to STREAM.
- STREAM:
  - enc_char_valid = 1, enc_char = char[idx], enc_char_last = (idx == eff_len-1).
  - On enc_char_ready: idx increments. If last, go to CLASSIFY.
  - enc_char and enc_char_last stay stable while valid is high and ready is low. No char is skipped or duplicated.
- CLASSIFY: cls_start = 1 for one cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - On cls_done: result <= cls_label (passed verbatim); go to DONE.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1 without cls_done: result <= 2'b11; go to DONE.
  - If cls_done and timeout coincide, cls_done wins.
- DONE: result_valid = 1 for one cycle; go to IDLE. result holds its value until the next DONE.
- msg_ready is 0 outside IDLE; msg_valid is ignored there. cls_done is ignored outside WAIT. enc_char_ready is ignored outside STREAM.
- Latency, with the handshake at cycle 0 and ready always high:
  - enc_clear at cycle 1.
  - Chars at cycles 2..N+1.
  - cls_start at cycle N+2.
  - With cls_done at cycle W, result_valid at cycle W+1.
  - For length 0, result_valid at cycle 1.
- idx is wide enough for MESSAGE_LENGTH-1. eff_len comparison is unsigned, with no wrap.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.

Test Plan:
- Basic classification:
  - Stimulus: length=3, chars "abc" (0x61,0x62,0x63), ready tied to 1, cls_done 2 cycles after cls_start with cls_label=01.
  - Response: enc_clear at cycle 1; chars on cycles 2-4 with last only on 0x63; cls_start at cycle 5; result_valid with result=01 at cycle 8.
- Backpressure:
  - Stimulus: length=4, enc_char_ready high only on even cycles.
  - Response: each char held stable until accepted; the accepted sequence equals chars 0..3 exactly once; cls_start fires one cycle after the last acceptance.
- Empty message:
  - Stimulus: length=0.
  - Response: no enc_clear, no enc_char_valid, no cls_start; result_valid at cycle 1 with result=11.
- Length clamp:
  - Stimulus: length=250.
  - Response: exactly 200 chars streamed; enc_char_last on index 199; the message is then classified normally.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16, cls_done never asserted.
  - Response: result_valid with result=11 exactly 16 cycles after entering WAIT; busy drops and msg_ready returns to 1 next cycle.
- Reset mid-stream:
  - Stimulus: assert reset while in STREAM at idx=5, then submit a new 2-char message.
  - Response: the cycle after reset, all outputs are at reset values with no result_valid; the new message streams from char 0 and produces a normal result.
